per_timer: RTL
==============

PER_TIMER -- requirements
Module: per_timer

Interface
REQ-001 SHALL have parameter BASE, default 16'h0160, byte address of the control register. The counter sits at BASE+16'h10 and the compare register at BASE+16'h12.
REQ-002 SHALL have parameter SIZE, default 16, data and counter width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (rst=0 resets).
REQ-005 MAB_in  input  16  memory address bus from the CPU.
REQ-006 MDB_in  input  16  write data from the CPU.
REQ-007 MW  input  1  write strobe; 1 = write this cycle.
REQ-008 BW  input  1  byte access; 1 = byte, 0 = word.
REQ-009 MDB_out  output  16  read data from the peripheral; 16'h0000 when not hit.
REQ-010 PER_hit  output  1  1 when MAB_in decodes to any of this block's three registers.
REQ-011 IRQ  output  1  interrupt request, equal to IE AND IFG.

Function
REQ-012 SHALL decode three word registers, comparing MAB_in[15:1] only:
  - CTL at BASE
  - TAR at BASE+16'h10
  - CCR0 at BASE+16'h12
REQ-013 CTL bit fields SHALL be:
  - [7:6] ID: prescale divide by 1/2/4/8
  - [5:4] MC: 00 stop, 01 up, 10 continuous, 11 up/down
  - [2] CLR: write-only, always reads 0
  - [1] IE
  - [0] IFG
  - all other bits read 0
REQ-014 Reads SHALL be combinational from MAB_in and BW, with zero-cycle latency.
REQ-015 A byte read SHALL return the addressed byte (MAB_in[0]=1 selects the high byte) zero-extended into [7:0].
REQ-016 Writes SHALL take effect on the rising clk edge when MW=1 and PER_hit=1; no-hit writes are ignored.
REQ-017 A byte write SHALL modify only the addressed byte, with MDB_in[7:0] as the data source. A word write SHALL modify all 16 bits.
REQ-018 The prescaler SHALL be a 3-bit counter. It SHALL produce a one-cycle tick when its value equals (2^ID)-1, then wrap to 0. The prescaler SHALL run only when MC!=00.
REQ-019 Up mode: on each tick, TAR increments. When TAR==CCR0 on a tick, TAR loads 0 and IFG sets.
REQ-020 Up mode with CCR0==0: TAR SHALL hold at 0 and IFG SHALL NOT set.
REQ-021 Continuous mode: on each tick, TAR increments and wraps from 16'hFFFF to 0; IFG sets on that wrap.
REQ-022 Up/down mode SHALL use a direction state with two states, UP and DOWN:
  - UP: increments; at TAR==CCR0 on a tick, switches to DOWN and decrements on the next tick.
  - DOWN: decrements; on the tick where TAR goes from 1 to 0, IFG sets and the state switches to UP.
REQ-023 Stop mode SHALL hold TAR, the prescaler and the direction state.
REQ-024 Writing CLR=1 SHALL zero TAR, zero the prescaler and force the direction to UP on that edge. ID, MC and IE SHALL still take their written values on that edge.
REQ-025 A CPU write to TAR SHALL override a coincident tick update on the same edge.
REQ-026 A hardware IFG set SHALL override a coincident CPU write of IFG=0.
REQ-027 A mode change SHALL NOT alter TAR. Entering up/down mode from any other mode SHALL start in UP.
REQ-028 TAR increments and decrements SHALL be modulo 2^SIZE.

Reset
REQ-029 With rst=0, the following SHALL be 0 immediately and without waiting for clk: CTL, TAR, CCR0, the prescaler, and the direction state (UP).
REQ-030 During and after reset, until the first write: IRQ=0, and MDB_out=0 for non-hit addresses.
REQ-031 Asserting rst mid-count SHALL abort counting immediately. After rst rises, the block SHALL stay stopped until CTL is written.

Verification
REQ-032 Up mode, divide by 1:
  - Stimulus: CCR0=3; CTL=16'h0012 (MC=01, IE=1).
  - Required: TAR sequence 0,1,2,3,0; IFG and IRQ go to 1 on the edge where TAR loads 0.
REQ-033 Divide by 8, continuous mode:
  - Stimulus: CTL=16'h00E0 (ID=11, MC=10), TAR=16'hFFFF.
  - Required: TAR becomes 0 exactly 8 clks later; IFG=1.
REQ-034 Up/down mode:
  - Stimulus: CCR0=2; MC=11.
  - Required: TAR sequence 0,1,2,1,0,1; IFG sets only on the 1->0 step.
REQ-035 Byte access:
  - Stimulus: byte write 8'hAB to BASE+16'h13 with CCR0 preset to 16'h1234.
  - Required: CCR0=16'hAB34; a byte read of BASE+16'h12 returns 16'h0034.
REQ-036 Collisions:
  - Stimulus A: TAR write of 16'h0100 on the same edge as a tick. Required: TAR=16'h0100.
  - Stimulus B: IFG-clear write on the same edge as a hardware IFG set. Required: IFG=1.
REQ-037 Reset mid-count:
  - Stimulus: drive rst=0 asynchronously while TAR=5 in up mode.
  - Required: TAR=0, CTL=0 and IRQ=0 before the next clk edge; TAR remains 0 for 10 clks after release.

Source files
------------

// File: rtl/per_timer.sv
// Memory-mapped 16-bit timer with a prescaler, four count modes and one compare register.
// It provides a combinational CPU read port and a registered interrupt request.
module per_timer #(
   parameter logic [15:0] BASE = 16'h0160,
   parameter int          SIZE = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] MAB_in,
   input  logic [15:0] MDB_in,
   input  logic        MW,
   input  logic        BW,
   output logic [15:0] MDB_out,
   output logic        PER_hit,
   output logic        IRQ
);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   localparam logic [15:0]     TAR_ADDR = BASE + 16'h0010;
   localparam logic [15:0]     CCR_ADDR = BASE + 16'h0012;
   localparam logic [1:0]      MC_STOP  = 2'b00;
   localparam logic [1:0]      MC_UP    = 2'b01;
   localparam logic [1:0]      MC_CONT  = 2'b10;
   localparam logic [1:0]      MC_UPDN  = 2'b11;
   localparam logic [SIZE-1:0] CNT_ONE  = {{(SIZE-1){1'b0}}, 1'b1};

   function automatic logic [15:0] merge_write(input logic [15:0] old_val, input logic [15:0] din,
                                               input logic byte_acc, input logic hi_byte);
      logic [15:0] res;
      if (!byte_acc) begin
         res = din;
      end else if (hi_byte) begin
         res = {din[7:0], old_val[7:0]};
      end else begin
         res = {old_val[15:8], din[7:0]};
      end
      return res;
   endfunction

   logic [1:0]      id_r, mc_r;
   logic            ie_r, ifg_r, irq_r;
   logic [SIZE-1:0] tar_r, ccr0_r;
   logic [2:0]      pre_r;
   dir_t            dir_r;

   logic            hit_ctl_s, hit_tar_s, hit_ccr_s;
   logic            wr_ctl_s, wr_tar_s, wr_ccr_s, clr_s;
   logic [15:0]     ctl_rd_s, tar_rd_s, ccr_rd_s, word_s;
   logic [15:0]     ctl_new_s, tar_new_s, ccr_new_s;
   logic [2:0]      pre_max_s, pre_nxt_s;
   logic            run_s, tick_s, hw_ifg_s;
   logic [SIZE-1:0] tar_cnt_s, tar_nxt_s;
   dir_t            dir_cnt_s, dir_nxt_s;
   logic [1:0]      id_nxt_s, mc_nxt_s;
   logic            ie_nxt_s, ifg_nxt_s;
   logic [SIZE-1:0] ccr_nxt_s;

   assign hit_ctl_s = (MAB_in[15:1] == BASE[15:1]);
   assign hit_tar_s = (MAB_in[15:1] == TAR_ADDR[15:1]);
   assign hit_ccr_s = (MAB_in[15:1] == CCR_ADDR[15:1]);
   assign PER_hit   = hit_ctl_s | hit_tar_s | hit_ccr_s;

   assign ctl_rd_s  = {8'h00, id_r, mc_r, 2'b00, ie_r, ifg_r};
   assign tar_rd_s  = 16'(tar_r);
   assign ccr_rd_s  = 16'(ccr0_r);

   assign wr_ctl_s  = MW & hit_ctl_s;
   assign wr_tar_s  = MW & hit_tar_s;
   assign wr_ccr_s  = MW & hit_ccr_s;
   assign ctl_new_s = merge_write(ctl_rd_s, MDB_in, BW, MAB_in[0]);
   assign tar_new_s = merge_write(tar_rd_s, MDB_in, BW, MAB_in[0]);
   assign ccr_new_s = merge_write(ccr_rd_s, MDB_in, BW, MAB_in[0]);
   assign clr_s     = wr_ctl_s & ctl_new_s[2];

   // Read mux: selected register, optionally narrowed to the addressed byte.
   always_comb begin
      word_s = 16'h0000;
      if (hit_ctl_s) begin
         word_s = ctl_rd_s;
      end else if (hit_tar_s) begin
         word_s = tar_rd_s;
      end else if (hit_ccr_s) begin
         word_s = ccr_rd_s;
      end else begin
         word_s = 16'h0000;
      end
      if (BW) begin
         MDB_out = MAB_in[0] ? {8'h00, word_s[15:8]} : {8'h00, word_s[7:0]};
      end else begin
         MDB_out = word_s;
      end
   end

   // Prescaler terminal value for the selected divide ratio.
   always_comb begin
      case (id_r)
         2'd0:    pre_max_s = 3'd0;
         2'd1:    pre_max_s = 3'd1;
         2'd2:    pre_max_s = 3'd3;
         2'd3:    pre_max_s = 3'd7;
         default: pre_max_s = 3'd0;
      endcase
   end

   assign run_s  = (mc_r != MC_STOP);
   assign tick_s = run_s && (pre_r == pre_max_s);

   // Count-mode behaviour on a prescaler tick, before CPU overrides.
   always_comb begin
      tar_cnt_s = tar_r;
      dir_cnt_s = dir_r;
      hw_ifg_s  = 1'b0;
      if (tick_s) begin
         case (mc_r)
            MC_UP: begin
               if (tar_r == ccr0_r) begin
                  tar_cnt_s = '0;
                  hw_ifg_s  = (ccr0_r != '0);
               end else begin
                  tar_cnt_s = tar_r + CNT_ONE;
               end
            end
            MC_CONT: begin
               tar_cnt_s = tar_r + CNT_ONE;
               hw_ifg_s  = (tar_r == '1);
            end
            MC_UPDN: begin
               if (ccr0_r == '0) begin
                  tar_cnt_s = tar_r;
               end else if (dir_r == DIR_UP) begin
                  if (tar_r == ccr0_r) begin
                     tar_cnt_s = tar_r - CNT_ONE;
                     dir_cnt_s = DIR_DOWN;
                  end else begin
                     tar_cnt_s = tar_r + CNT_ONE;
                  end
               end else begin
                  tar_cnt_s = tar_r - CNT_ONE;
                  if (tar_r == CNT_ONE) begin
                     hw_ifg_s  = 1'b1;
                     dir_cnt_s = DIR_UP;
                  end else begin
                     dir_cnt_s = DIR_DOWN;
                  end
               end
            end
            default: tar_cnt_s = tar_r;
         endcase
      end else begin
         tar_cnt_s = tar_r;
      end
   end

   // Next-state merge: CPU writes and CLR take priority, except a hardware IFG set wins.
   always_comb begin
      tar_nxt_s = tar_cnt_s;
      pre_nxt_s = pre_r;
      dir_nxt_s = dir_cnt_s;
      id_nxt_s  = id_r;
      mc_nxt_s  = mc_r;
      ie_nxt_s  = ie_r;
      ifg_nxt_s = ifg_r;
      ccr_nxt_s = ccr0_r;
      if (wr_tar_s) begin
         tar_nxt_s = tar_new_s[SIZE-1:0];
      end else if (clr_s) begin
         tar_nxt_s = '0;
      end else begin
         tar_nxt_s = tar_cnt_s;
      end
      if (clr_s || tick_s) begin
         pre_nxt_s = 3'd0;
      end else if (run_s) begin
         pre_nxt_s = pre_r + 3'd1;
      end else begin
         pre_nxt_s = pre_r;
      end
      if (clr_s || (wr_ctl_s && (ctl_new_s[5:4] == MC_UPDN) && (mc_r != MC_UPDN))) begin
         dir_nxt_s = DIR_UP;
      end else begin
         dir_nxt_s = dir_cnt_s;
      end
      if (wr_ctl_s) begin
         id_nxt_s  = ctl_new_s[7:6];
         mc_nxt_s  = ctl_new_s[5:4];
         ie_nxt_s  = ctl_new_s[1];
         ifg_nxt_s = ctl_new_s[0] | hw_ifg_s;
      end else begin
         ifg_nxt_s = ifg_r | hw_ifg_s;
      end
      if (wr_ccr_s) begin
         ccr_nxt_s = ccr_new_s[SIZE-1:0];
      end else begin
         ccr_nxt_s = ccr0_r;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_r   <= 2'b00;
         mc_r   <= 2'b00;
         ie_r   <= 1'b0;
         ifg_r  <= 1'b0;
         irq_r  <= 1'b0;
         tar_r  <= '0;
         ccr0_r <= '0;
         pre_r  <= 3'd0;
         dir_r  <= DIR_UP;
      end else begin
         id_r   <= id_nxt_s;
         mc_r   <= mc_nxt_s;
         ie_r   <= ie_nxt_s;
         ifg_r  <= ifg_nxt_s;
         irq_r  <= ie_nxt_s & ifg_nxt_s;
         tar_r  <= tar_nxt_s;
         ccr0_r <= ccr_nxt_s;
         pre_r  <= pre_nxt_s;
         dir_r  <= dir_nxt_s;
      end
   end

   assign IRQ = irq_r;

endmodule
